// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared ALU definitions for the bit-serial adder: state
//               encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int C_DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_adder_full_add_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_add_cell
// Description : Combinational one-bit full adder made of two half-add
//               stages and an OR that merges their carries.
// Revision    : 1.0 - initial release
// ============================================================================
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_h1_s;
    logic w_h1_c;
    logic w_h2_c;

    // First half-add stage on the operand bits
    assign w_h1_s = a ^ b;
    assign w_h1_c = a & b;

    // Second half-add stage folds in the incoming carry
    assign s      = w_h1_s ^ cin;
    assign w_h2_c = w_h1_s & cin;

    // At most one stage can generate a carry, so an OR combines them
    assign cout   = w_h1_c | w_h2_c;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial ripple adder. Captures two operands and a carry-in
//               on start, adds one bit per clock LSB first through a single
//               full-adder cell, and presents sum, carry-out and signed
//               overflow with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int                  C_CNT_W = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0]  C_LAST  = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0]  C_ONE   = C_CNT_W'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Partial sum: only WIDTH-1 bits need storing, the newest bit comes
    // straight from the cell on the final cycle.
    logic [WIDTH-2:0]   r_part;
    logic               r_carry;
    logic [C_CNT_W-1:0] r_cnt;

    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_sum_cat;

    full_add_cell u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits in sum[0]
    assign w_sum_cat = {w_s, r_part};

    // Control FSM, operand/sum shifting and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_part    <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= carry_in;
                        r_part  <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_part  <= w_sum_cat[WIDTH-1:1];
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + C_ONE;
                    if (r_cnt == C_LAST) begin
                        // Old carry flop is the carry into the MSB
                        sum       <= w_sum_cat;
                        carry_out <= w_c;
                        overflow  <= r_carry ^ w_c;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
